// File: rtl/conv_adder_tree.sv
// rtl/conv_adder_tree.sv - pipelined saturating adder tree reducing one kernel window to a single sum
// Define CONV_ADDER_TREE_BIAS_EN to add a per-window bias input carried alongside the products.
module conv_adder_tree #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BIT    = 8,
  parameter int KERNEL_SIZE = 5
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] products,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  output logic [DATA_WIDTH-1:0]                         sum_out,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic                                          sat_flag,
  output logic                                          sat_sticky,
  output logic [31:0]                                   window_count
`ifdef CONV_ADDER_TREE_BIAS_EN
  ,
  input  logic [DATA_WIDTH-1:0]                         bias
`endif
);

  // Integer and fraction bits together form the word; the binary point never moves here.
  localparam int INT_BITS = DATA_WIDTH - FRAC_BIT;
  localparam int DW       = INT_BITS + FRAC_BIT;
  localparam int N        = KERNEL_SIZE * KERNEL_SIZE;
  localparam int LEVELS   = $clog2(N);
  localparam int LEAVES   = 1 << LEVELS;
`ifdef CONV_ADDER_TREE_BIAS_EN
  localparam int SUM_WIDTH = DW + LEVELS + 1;
`else
  localparam int SUM_WIDTH = DW + LEVELS;
`endif

  localparam logic signed [SUM_WIDTH-1:0] SAT_MAX = {{(SUM_WIDTH-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SUM_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  logic                        advance;
  logic signed [SUM_WIDTH-1:0] leaf [LEAVES];
  logic signed [SUM_WIDTH-1:0] node [1:LEAVES-1];
  logic [LEVELS:1]             vld;
  logic signed [SUM_WIDTH-1:0] total;
  logic [DW-1:0]               sat_val;
  logic                        sat_hit;

  // The whole pipe freezes while the output beat is held; no bubble is squeezed out.
  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
    if (i < N) begin : g_tap
      assign leaf[i] = SUM_WIDTH'($signed(products[i*DW +: DW]));
    end else begin : g_pad
      assign leaf[i] = '0;
    end
  end

  // Heap-ordered tree: node j sums children 2j and 2j+1; indices >= LEAVES map onto the leaves.
  for (genvar j = 1; j < LEAVES; j++) begin : g_node
    logic signed [SUM_WIDTH-1:0] lhs;
    logic signed [SUM_WIDTH-1:0] rhs;
    if (2*j >= LEAVES) begin : g_from_leaf
      assign lhs = leaf[2*j - LEAVES];
      assign rhs = leaf[2*j + 1 - LEAVES];
    end else begin : g_from_node
      assign lhs = node[2*j];
      assign rhs = node[2*j + 1];
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        node[j] <= '0;
      end else if (advance) begin
        node[j] <= lhs + rhs;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else if (advance) begin
      vld[1] <= in_valid;
      for (int k = 2; k <= LEVELS; k++) begin
        vld[k] <= vld[k-1];
      end
    end
  end

`ifdef CONV_ADDER_TREE_BIAS_EN
  logic [DW-1:0] bias_q [1:LEVELS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= LEVELS; k++) begin
        bias_q[k] <= '0;
      end
    end else if (advance) begin
      bias_q[1] <= bias;
      for (int k = 2; k <= LEVELS; k++) begin
        bias_q[k] <= bias_q[k-1];
      end
    end
  end
`endif

  always_comb begin
    total = node[1];
`ifdef CONV_ADDER_TREE_BIAS_EN
    total = node[1] + SUM_WIDTH'($signed(bias_q[LEVELS]));
`endif
    sat_val = total[DW-1:0];
    sat_hit = 1'b0;
    if (total > SAT_MAX) begin
      sat_val = {1'b0, {(DW-1){1'b1}}};
      sat_hit = 1'b1;
    end else if (total < SAT_MIN) begin
      sat_val = {1'b1, {(DW-1){1'b0}}};
      sat_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      sum_out      <= '0;
      sat_flag     <= 1'b0;
      sat_sticky   <= 1'b0;
      window_count <= '0;
    end else begin
      if (advance) begin
        out_valid <= vld[LEVELS];
        sum_out   <= sat_val;
        sat_flag  <= sat_hit;
      end
      if (out_valid && out_ready) begin
        window_count <= window_count + 32'd1;
        if (sat_flag) begin
          sat_sticky <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_adder_tree.sv
// tb/tb_conv_adder_tree.sv - randomized self-checking bench for conv_adder_tree
// Reference sums come from plain integer arithmetic on the window taps.
module tb_conv_adder_tree;

  localparam int DW  = 16;
  localparam int KS  = 5;
  localparam int N   = KS * KS;
  localparam int LAT = 5;
`ifdef CONV_ADDER_TREE_BIAS_EN
  localparam bit BIAS_ON = 1'b1;
`else
  localparam bit BIAS_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*DW-1:0] products;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   sum_out;
  logic            out_valid;
  logic            out_ready;
  logic            sat_flag;
  logic            sat_sticky;
  logic [31:0]     window_count;
  logic [DW-1:0]   bias_v;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  conv_adder_tree #(
    .DATA_WIDTH  (DW),
    .FRAC_BIT    (8),
    .KERNEL_SIZE (KS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .products     (products),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .sum_out      (sum_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .sat_flag     (sat_flag),
    .sat_sticky   (sat_sticky),
    .window_count (window_count)
`ifdef CONV_ADDER_TREE_BIAS_EN
    ,
    .bias         (bias_v)
`endif
  );

  function automatic logic [N*DW-1:0] fill(input logic [DW-1:0] v);
    logic [N*DW-1:0] p;
    for (int i = 0; i < N; i++) p[i*DW +: DW] = v;
    return p;
  endfunction

  function automatic logic [N*DW-1:0] gen_window(input bit wide);
    logic [N*DW-1:0] p;
    for (int i = 0; i < N; i++)
      p[i*DW +: DW] = wide ? DW'($urandom) : DW'($urandom_range(0, 2047) - 1024);
    return p;
  endfunction

  function automatic void model(input logic [N*DW-1:0] p, input logic [DW-1:0] b,
                                output logic [DW-1:0] s, output logic f);
    longint acc = 0;
    for (int i = 0; i < N; i++) acc += longint'($signed(p[i*DW +: DW]));
    if (BIAS_ON) acc += longint'($signed(b));
    f = 1'b1;
    if (acc > 32767) s = 16'h7FFF;
    else if (acc < -32768) s = 16'h8000;
    else begin
      s = acc[15:0];
      f = 1'b0;
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; products = '0; bias_v = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_one(input logic [N*DW-1:0] p, input logic [DW-1:0] b,
                          output logic [DW-1:0] s, output logic f, output int lat);
    @(negedge clk);
    products = p; bias_v = b; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = -1;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = e;
        break;
      end
    end
    s = sum_out; f = sat_flag;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; products = '0; bias_v = '0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid_during: got %b expected 0", out_valid); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (sum_out !== 16'h0000) begin n_fail++; $display("FAIL reset_sum_out: got %h expected 0000", sum_out); end
    n_cmp++; if (sat_flag !== 1'b0 || sat_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %b%b expected 00", sat_flag, sat_sticky); end
    n_cmp++; if (window_count !== 32'd0) begin n_fail++; $display("FAIL reset_window_count: got %0d expected 0", window_count); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] s; logic f; int lat;
    do_reset();
    send_one(fill(16'h0100), '0, s, f, lat);
    n_cmp++; if (lat !== LAT) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", lat, LAT); end
    n_cmp++; if (s !== 16'h1900) begin n_fail++; $display("FAIL basic_sum: got %h expected 1900", s); end
    n_cmp++; if (f !== 1'b0) begin n_fail++; $display("FAIL basic_sat_flag: got %b expected 0", f); end
    n_cmp++; if (window_count !== 32'd1) begin n_fail++; $display("FAIL basic_window_count: got %0d expected 1", window_count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_out_valid_drop: got %b expected 0", out_valid); end
  endtask

  task automatic test_saturation();
    logic [DW-1:0] s; logic f; int lat; logic [N*DW-1:0] p;
    do_reset();
    send_one(fill(16'h7FFF), '0, s, f, lat);
    n_cmp++; if (s !== 16'h7FFF || f !== 1'b1) begin n_fail++; $display("FAIL pos_sat: got %h/%b expected 7fff/1", s, f); end
    n_cmp++; if (sat_sticky !== 1'b1) begin n_fail++; $display("FAIL pos_sat_sticky: got %b expected 1", sat_sticky); end
    send_one(fill(16'h0001), '0, s, f, lat);
    n_cmp++; if (s !== 16'h0019 || f !== 1'b0) begin n_fail++; $display("FAIL small_sum: got %h/%b expected 0019/0", s, f); end
    n_cmp++; if (sat_sticky !== 1'b1) begin n_fail++; $display("FAIL sticky_hold: got %b expected 1", sat_sticky); end
    send_one(fill(16'h8000), '0, s, f, lat);
    n_cmp++; if (s !== 16'h8000 || f !== 1'b1) begin n_fail++; $display("FAIL neg_sat: got %h/%b expected 8000/1", s, f); end
    p = fill(16'hFFF0);
    p[0 +: DW] = 16'h0300;
    send_one(p, '0, s, f, lat);
    n_cmp++; if (s !== 16'h0180 || f !== 1'b0) begin n_fail++; $display("FAIL mixed_sign: got %h/%b expected 0180/0", s, f); end
    n_cmp++; if (window_count !== 32'd4) begin n_fail++; $display("FAIL sat_window_count: got %0d expected 4", window_count); end
  endtask

  // mode 0: windows of constant k=1..n with out_ready low on cycles 6..12; mode 1: random everything
  task automatic run_stream(input int nwin, input bit rnd, input string name);
    logic [DW-1:0] exp_s[$];
    logic          exp_f[$];
    logic [N*DW-1:0] cur;
    logic [DW-1:0] es; logic ef;
    int sent = 0, got = 0, stalls = 0;
    do_reset();
    cur = rnd ? gen_window($urandom_range(0, 1) == 1) : fill(DW'(1));
    bias_v = rnd ? DW'($urandom_range(0, 1023) - 512) : '0;
    for (int cyc = 0; cyc < 3000 && got < nwin; cyc++) begin
      @(negedge clk);
      products  = cur;
      in_valid  = (sent < nwin) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      out_ready = rnd ? ($urandom_range(0, 2) != 0) : !(cyc >= 6 && cyc <= 12);
      #1;
      if (out_valid && !out_ready) stalls++;
      n_cmp++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        n_fail++; $display("FAIL %s_in_ready cyc %0d: got %b expected %b", name, cyc, in_ready, !(out_valid && !out_ready));
      end
      if (out_valid && out_ready) begin
        got++;
        n_cmp++;
        if (exp_s.size() == 0) begin
          n_fail++; $display("FAIL %s_spurious_output: got %h expected none", name, sum_out);
        end else begin
          es = exp_s.pop_front(); ef = exp_f.pop_front();
          if (sum_out !== es || sat_flag !== ef) begin
            n_fail++; $display("FAIL %s_output %0d: got %h/%b expected %h/%b", name, got, sum_out, sat_flag, es, ef);
          end
        end
      end
      if (in_valid && in_ready) begin
        model(cur, bias_v, es, ef);
        exp_s.push_back(es); exp_f.push_back(ef);
        sent++;
        cur = rnd ? gen_window($urandom_range(0, 1) == 1) : fill(DW'(sent + 1));
        if (rnd) bias_v = DW'($urandom_range(0, 1023) - 512);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    n_cmp++; if (got !== nwin || exp_s.size() != 0) begin n_fail++; $display("FAIL %s_count: got %0d outputs expected %0d", name, got, nwin); end
    n_cmp++; if (window_count !== 32'(nwin)) begin n_fail++; $display("FAIL %s_window_count: got %0d expected %0d", name, window_count, nwin); end
    n_cmp++; if (stalls == 0) begin n_fail++; $display("FAIL %s_no_stall_seen: got %0d stalled cycles expected >0", name, stalls); end
  endtask

  task automatic test_backpressure();
    run_stream(8, 1'b0, "backpressure");
  endtask

  task automatic test_random();
    run_stream(60, 1'b1, "random");
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] s; logic f; int lat; int seen = 0;
    do_reset();
    send_one(fill(16'h7FFF), '0, s, f, lat);
    n_cmp++; if (sat_sticky !== 1'b1 || window_count !== 32'd1) begin n_fail++; $display("FAIL midrst_pre: got %b/%0d expected 1/1", sat_sticky, window_count); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      products = fill(DW'(k)); in_valid = 1'b1; out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL midrst_residual: got %0d outputs expected 0", seen); end
    n_cmp++; if (window_count !== 32'd0) begin n_fail++; $display("FAIL midrst_window_count: got %0d expected 0", window_count); end
    n_cmp++; if (sat_sticky !== 1'b0) begin n_fail++; $display("FAIL midrst_sticky: got %b expected 0", sat_sticky); end
  endtask

`ifdef CONV_ADDER_TREE_BIAS_EN
  task automatic test_bias();
    logic [DW-1:0] s; logic f; int lat;
    do_reset();
    send_one(fill(16'h0100), 16'hFF00, s, f, lat);
    n_cmp++; if (s !== 16'h1800 || f !== 1'b0) begin n_fail++; $display("FAIL bias_sum: got %h/%b expected 1800/0", s, f); end
    n_cmp++; if (lat !== LAT) begin n_fail++; $display("FAIL bias_latency: got %0d expected %0d", lat, LAT); end
    send_one(fill(16'h7FFF), 16'h8000, s, f, lat);
    n_cmp++; if (s !== 16'h7FFF || f !== 1'b1) begin n_fail++; $display("FAIL bias_sat: got %h/%b expected 7fff/1", s, f); end
  endtask
`endif

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; products = '0; bias_v = '0;
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_random();
    test_reset_mid();
`ifdef CONV_ADDER_TREE_BIAS_EN
    test_bias();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_adder_tree.md
Name: conv_adder_tree

Overview:
- Downstream stage of the per-tap product multiplier in the convolver datapath.
- Takes the KERNEL_SIZE**2 truncated signed fixed-point products from one window and reduces them to a single convolution sum per window.
- Pipelined binary adder tree; sums are carried at full growth width, then saturated to DATA_WIDTH.
- Valid/ready handshake on both sides, with a global stall under backpressure.

Parameters:
- DATA_WIDTH, 16, width of each product and of the output sum, signed two's complement.
- FRAC_BIT, 8, fractional bits of products and output (Q(DATA_WIDTH-FRAC_BIT).FRAC_BIT); informational only, no rescaling performed.
- KERNEL_SIZE, 5, kernel edge; N = KERNEL_SIZE**2 products per window.
- LEVELS (localparam) = $clog2(N); 5 at defaults.
- SUM_WIDTH (localparam) = DATA_WIDTH + LEVELS; internal accumulation width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- products  input  N*DATA_WIDTH  flattened signed products; tap i at [i*DATA_WIDTH +: DATA_WIDTH].
- in_valid  input  1  products valid this cycle.
- in_ready  output  1  stage accepts products this cycle.
- sum_out  output  DATA_WIDTH  saturated convolution sum.
- out_valid  output  1  sum_out valid.
- out_ready  input  1  consumer accepts sum_out.
- sat_flag  output  1  sum_out of the current output beat was clipped.
- sat_sticky  output  1  latched high on any clipped output until reset.
- window_count  output  32  number of completed output handshakes, wraps at 2**32.

Behaviour:
- Reset (async assert, sync-to-clk release):
  - All pipeline valid bits, partial sums, sum_out, out_valid, sat_flag, sat_sticky and window_count are cleared to 0.
  - in_ready is 1 from the first cycle after reset.
- Tree structure:
  - Level 0 sign-extends each product to SUM_WIDTH.
  - Leaves beyond N, up to 2**LEVELS, are zero.
  - Each level k (1..LEVELS) registers pairwise sums of level k-1.
  - The final saturation stage is combinational on the level-LEVELS register, which directly drives the output registers.
- Latency: an accepted window produces out_valid exactly LEVELS cycles after the in_valid&&in_ready cycle (5 at defaults), when not stalled.
- Throughput: one window per cycle.
- Stall rule:
  - stall = out_valid && !out_ready.
  - in_ready = !stall.
  - While stalled, every pipeline register, including the valid bits, holds its value.
  - No bubble is collapsed; the whole pipe freezes.
  - in_ready is combinational from out_valid/out_ready; there is no combinational path from in_valid to any output.
- Valid propagation: a per-level valid bit shifts with the data. A level with valid=0 still clocks data, but its contents are don't-care.
- Saturation:
  - Let S be the SUM_WIDTH result.
  - If S > 2**(DATA_WIDTH-1)-1, sum_out = 0x7FFF (for 16 bits). If S < -2**(DATA_WIDTH-1), sum_out = 0x8000. Otherwise sum_out = S[DATA_WIDTH-1:0].
  - sat_flag is registered alongside sum_out and is meaningful only while out_valid=1.
  - sat_sticky is set on any out_valid&&out_ready beat with sat_flag=1.
- window_count increments on each out_valid&&out_ready and wraps from 0xFFFFFFFF to 0.
- Simultaneous events: a new input may be accepted in the same cycle the output handshake completes (out_ready=1 implies in_ready=1).
- Reset mid-operation discards all in-flight windows; none are emitted after reset release.

Optional Feature:
- Macro: CONV_ADDER_TREE_BIAS_EN.
- When defined:
  - Adds input port bias, DATA_WIDTH wide, signed, same Q format.
  - bias is sampled with products on the in_valid&&in_ready cycle and carried through the pipeline with its window.
  - bias is sign-extended and added to S before saturation.
  - SUM_WIDTH grows by 1.
  - Latency is unchanged.
- When undefined: no bias port; the result is the pure product sum.

Test Plan:
- Basic sum and latency: all 25 products = 0x0100 (1.0), out_ready=1 → sum_out=0x1900 exactly 5 cycles after acceptance; sat_flag=0; window_count=1.
- Positive saturation: all products = 0x7FFF → sum_out=0x7FFF, sat_flag=1, sat_sticky=1. Then all products = 0x0001 → sum_out=0x0019, sat_flag=0, sat_sticky stays 1.
- Negative saturation and mixed sign:
  - All products = 0x8000 → sum_out=0x8000, sat_flag=1.
  - Tap 0 = 0x0300, remaining 24 taps = 0xFFF0 → sum_out=0x0180, no saturation.
- Backpressure: stream 8 back-to-back windows with values 1..8 (all taps = k) while holding out_ready=0 from cycle 6 to cycle 12 → in_ready=0 during the stall; no window is lost or duplicated; outputs arrive in order as 25*k; window_count=8.
- Reset mid-operation: accept 3 windows, then assert rst_n=0 for 1 cycle, 2 cycles after the last acceptance → out_valid stays 0 after release with no residual outputs; window_count=0; sat_sticky=0.
- Bias (with CONV_ADDER_TREE_BIAS_EN): all taps = 0x0100 with bias = 0xFF00 (-1.0) → sum_out=0x1800. All taps = 0x7FFF with bias = 0x8000 → sum_out=0x7FFF, sat_flag=1.
